uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_receiver_if.sv | 32 +++
 rtl/uart_sync.sv | 29 ++
 rtl/uart_receiver.sv | 151 +++++++++++++++
 tb/tb_uart_receiver.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: receiver state encoding, default oversampling
// factor and frame geometry. Users of uart_sender can import these as well.
// Ports: none (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   // sample_en strobes per bit period unless a design overrides it
   localparam int OVERSAMPLE_DEFAULT = 16;

   // 8N1 framing
   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_t;

   // Last counter value before the middle of the start bit.
   function automatic int half_bit_last(input int oversample);
      return oversample / 2 - 1;
   endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
// Groups the receiver's line-side inputs and byte-side outputs.
//   sample_en  : oversampling strobe (one clk_in cycle wide)
//   rx_in      : asynchronous serial line, idle high
//   data_out   : last correctly framed byte
//   data_valid : one-cycle pulse when data_out is updated
//   frame_err  : one-cycle pulse when a stop bit is sampled low
//   busy       : receiver is not idle
// master drives the line/strobe, slave is the receiver.
// -----------------------------------------------------------------------------
interface uart_receiver_if;
   import uart_pkg::*;

   logic                 sample_en;
   logic                 rx_in;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output sample_en, rx_in,
      input  data_out, data_valid, frame_err, busy
   );

   modport slave (
      input  sample_en, rx_in,
      output data_out, data_valid, frame_err, busy
   );

endinterface

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// 1 (line idle) so a reset never looks like a start bit.
//   clk_in    : system clock
//   reset     : asynchronous, active-low
//   line      : asynchronous input
//   line_sync : synchronized output, 2 clk_in cycles latency
// -----------------------------------------------------------------------------
module uart_sync (
   input  logic clk_in,
   input  logic reset,
   input  logic line,
   output logic line_sync
);

   logic [1:0] sync_reg;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], line};
      end
   end

   assign line_sync = sync_reg[1];

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver, LSB first, oversampled by OVERSAMPLE sample_en strobes
// per bit. Start bit is confirmed at its middle; data and stop bits are then
// sampled one full bit period apart, i.e. also near their middles.
//   clk_in : system clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : uart_receiver_if.slave (sample_en, rx_in in; data_out,
//            data_valid, frame_err, busy out)
// Parameter OVERSAMPLE must be even and >= 4.
// -----------------------------------------------------------------------------
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic           clk_in,
   input  logic           reset,
   uart_receiver_if.slave bus
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit_last(OVERSAMPLE));
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic                 rx_sync;

   rx_state_t            state_reg,  state_next;
   logic [CNT_W-1:0]     cnt_reg,    cnt_next;
   logic [2:0]           bit_reg,    bit_next;
   logic [DATA_BITS-1:0] shift_reg,  shift_next;
   logic [DATA_BITS-1:0] data_reg,   data_next;
   logic                 valid_reg,  valid_next;
   logic                 err_reg,    err_next;

   uart_sync u_sync (
      .clk_in    (clk_in),
      .reset     (reset),
      .line      (bus.rx_in),
      .line_sync (rx_sync)
   );

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         data_reg  <= '0;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         data_reg  <= data_next;
         valid_reg <= valid_next;
         err_reg   <= err_next;
      end
   end

   // Everything advances only on sample_en; pulses default low so they last
   // exactly one cycle after the deciding strobe.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      data_next  = data_reg;
      valid_next = 1'b0;
      err_next   = 1'b0;

      if (bus.sample_en) begin
         case (state_reg)
            IDLE: begin
               if (!rx_sync) begin
                  state_next = START;
                  cnt_next   = '0;
               end
            end

            START: begin
               if (cnt_reg == HALF_LAST) begin
                  cnt_next = '0;
                  if (!rx_sync) begin
                     state_next = DATA;
                     bit_next   = '0;
                  end else begin
                     // line went back high before mid start bit: glitch
                     state_next = IDLE;
                  end
               end else begin
                  cnt_next = cnt_reg + CNT_ONE;
               end
            end

            DATA: begin
               if (cnt_reg == FULL_LAST) begin
                  cnt_next   = '0;
                  shift_next = {rx_sync, shift_reg[DATA_BITS-1:1]};
                  if (bit_reg == 3'd7) begin
                     state_next = STOP;
                     bit_next   = '0;
                  end else begin
                     bit_next = bit_reg + 3'd1;
                  end
               end else begin
                  cnt_next = cnt_reg + CNT_ONE;
               end
            end

            STOP: begin
               if (cnt_reg == FULL_LAST) begin
                  cnt_next = '0;
                  if (rx_sync) begin
                     data_next  = shift_reg;
                     valid_next = 1'b1;
                     state_next = IDLE;
                  end else begin
                     err_next   = 1'b1;
                     state_next = WAIT_IDLE;
                  end
               end else begin
                  cnt_next = cnt_reg + CNT_ONE;
               end
            end

            WAIT_IDLE: begin
               // a held-low line (break) parks here without further errors
               if (rx_sync) begin
                  state_next = IDLE;
               end
            end

            default: begin
               state_next = IDLE;
               cnt_next   = '0;
               bit_next   = '0;
            end
         endcase
      end
   end

   assign bus.data_out   = data_reg;
   assign bus.data_valid = valid_reg;
   assign bus.frame_err  = err_reg;
   assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Drives 8N1 frames onto rx_in aligned to the sample_en cadence and compares
// every data_valid / frame_err event against a frame-level expectation queue.
// -----------------------------------------------------------------------------
module tb_uart_receiver;
   import uart_pkg::*;

   localparam int OS = 16;

   logic clk_in = 1'b0;
   logic reset;

   uart_receiver_if bus();

   uart_receiver #(.OVERSAMPLE(OS)) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   int n_compared   = 0;
   int n_mismatched = 0;
   int se_period    = 3;

   // events: {is_frame_err, data_out}
   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];
   logic [7:0] last_good;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // sample_en: one cycle high every se_period cycles
   initial begin
      int ph;
      ph = 0;
      bus.sample_en = 1'b0;
      forever begin
         @(negedge clk_in);
         ph++;
         if (ph >= se_period) ph = 0;
         bus.sample_en = (ph == 0);
      end
   end

   // event monitor, sampled on the falling edge
   always @(negedge clk_in) begin
      if (bus.data_valid || bus.frame_err) begin
         check_value("dv_fe_exclusive", 32'(bus.data_valid & bus.frame_err), 32'd0);
         got_q.push_back({bus.frame_err, bus.data_out});
         $display("rx event t=%0t %s data_out=0x%02h", $time,
                  bus.frame_err ? "frame_err " : "data_valid", bus.data_out);
      end
   end

   task automatic wait_samples(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in);
         while (bus.sample_en !== 1'b1) @(posedge clk_in);
      end
   endtask

   task automatic drive_bit(input logic v);
      @(negedge clk_in);
      bus.rx_in = v;
      wait_samples(OS);
   endtask

   task automatic idle(input int n);
      @(negedge clk_in);
      bus.rx_in = 1'b1;
      wait_samples(n);
   endtask

   // Sends the first nbits of {stop, b, start}; only complete frames create
   // an expectation.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits = 10);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      for (int i = 0; i < nbits; i++) drive_bit(frame[i]);
      if (nbits == 10) begin
         if (stop) begin
            exp_q.push_back({1'b0, b});
            last_good = b;
         end else begin
            exp_q.push_back({1'b1, last_good});
         end
      end
   endtask

   task automatic check_events(input string tag);
      int n;
      check_value({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check_value(tag, 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      bus.rx_in = 1'b1;
      last_good = 8'h00;
      #2 reset  = 1'b0;
      repeat (3) @(negedge clk_in);
      check_value("reset_data_out", 32'(bus.data_out), 32'h00);
      check_value("reset_data_valid", 32'(bus.data_valid), 32'd0);
      check_value("reset_frame_err", 32'(bus.frame_err), 32'd0);
      check_value("reset_busy", 32'(bus.busy), 32'd0);
      @(negedge clk_in);
      reset = 1'b1;
      idle(2 * OS);

      // single good frame
      send_frame(8'hA5, 1'b1);
      idle(OS);
      check_events("frame_a5");
      check_value("a5_data_out", 32'(bus.data_out), 32'hA5);

      // short low glitch on an idle line
      @(negedge clk_in);
      bus.rx_in = 1'b0;
      wait_samples(4);
      idle(2 * OS);
      check_value("glitch_busy", 32'(bus.busy), 32'd0);
      check_events("glitch");
      check_value("glitch_data_out", 32'(bus.data_out), 32'(last_good));

      // bad stop bit followed by a break
      send_frame(8'h3C, 1'b0);
      wait_samples(40);
      check_value("break_busy", 32'(bus.busy), 32'd1);
      check_events("break_err");
      idle(4);
      check_value("break_release_busy", 32'(bus.busy), 32'd0);
      check_events("break_release");
      check_value("break_data_out", 32'(bus.data_out), 32'hA5);

      // back-to-back frames
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h81, 1'b1);
      idle(OS);
      check_events("back_to_back");

      // reset in the middle of bit 4 of 8'h55
      send_frame(8'h55, 1'b1, 5);
      @(negedge clk_in);
      bus.rx_in = 1'b1;
      wait_samples(OS / 2);
      check_value("abort_busy_before", 32'(bus.busy), 32'd1);
      @(negedge clk_in);
      reset = 1'b0;
      repeat (2) @(negedge clk_in);
      check_value("abort_busy_in_reset", 32'(bus.busy), 32'd0);
      check_value("abort_data_out_reset", 32'(bus.data_out), 32'h00);
      last_good = 8'h00;
      reset = 1'b1;
      idle(2 * OS);
      check_events("abort");
      send_frame(8'h12, 1'b1);
      idle(OS);
      check_events("after_abort");
      check_value("after_abort_data_out", 32'(bus.data_out), 32'h12);

      // randomized frames, gaps and occasional bad stop bits
      se_period = 2;
      idle(4);
      for (int k = 0; k < 24; k++) begin
         logic [7:0] b;
         logic       stop;
         b    = 8'($urandom);
         stop = ($urandom_range(0, 7) != 0);
         send_frame(b, stop);
         if (!stop) begin
            wait_samples($urandom_range(0, 30));
            idle($urandom_range(2, 20));
         end else begin
            idle($urandom_range(0, 20));
         end
      end
      idle(OS);
      check_events("random");

      // counting sweep as a uart_sender would emit it, no gaps
      se_period = 1;
      idle(4);
      for (int v = 0; v < 256; v++) send_frame(8'(v), 1'b1);
      idle(OS);
      check_events("sweep");
      check_value("sweep_busy", 32'(bus.busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
